// File: rtl/vgachargen_mem_arb.sv
// Single-port memory arbiter: VGA character fetch (priority) vs. APB register access.
// Optional APB starvation guard: define VGACHARGEN_MEM_ARB_STARVE_GUARD_EN.
module vgachargen_mem_arb #(
   parameter int unsigned ADDR_WIDTH   = 12,
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned LATENCY      = 2,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                  clk_i,
   input  logic                  arst_i,
   input  logic                  vga_req_i,
   input  logic [ADDR_WIDTH-1:0] vga_addr_i,
   output logic                  vga_rvalid_o,
   output logic [DATA_WIDTH-1:0] vga_rdata_o,
   output logic                  vga_miss_o,
   input  logic                  apb_req_i,
   input  logic                  apb_we_i,
   input  logic [ADDR_WIDTH-1:0] apb_addr_i,
   input  logic [DATA_WIDTH-1:0] apb_wdata_i,
   output logic                  apb_gnt_o,
   output logic                  apb_rvalid_o,
   output logic [DATA_WIDTH-1:0] apb_rdata_o,
   output logic                  mem_en_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   if (LATENCY == 0 || STARVE_LIMIT == 0) begin : g_bad_param
      $error("vgachargen_mem_arb: LATENCY and STARVE_LIMIT must be >= 1");
   end

   typedef enum logic {
      ST_IDLE,
      ST_RD_WAIT
   } apb_state_t;

   apb_state_t          state;
   logic [LATENCY-1:0]  tag_v;
   logic [LATENCY-1:0]  tag_apb;
   logic                apb_win;
   logic                vga_issue;
   logic                rd_issue;
   logic                starved;

`ifdef VGACHARGEN_MEM_ARB_STARVE_GUARD_EN
   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] starve_cnt;

   assign starved    = (starve_cnt >= CNT_W'(STARVE_LIMIT));
   assign vga_miss_o = vga_req_i & apb_win;

   // Counts IDLE cycles an APB request spends losing to VGA; cleared by a grant.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         starve_cnt <= '0;
      end else if (apb_win) begin
         starve_cnt <= '0;
      end else if (state == ST_IDLE && apb_req_i && !starved) begin
         starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end
`else
   assign starved    = 1'b0;
   assign vga_miss_o = 1'b0;
`endif

   always_comb begin
      apb_win   = 1'b0;
      vga_issue = 1'b0;
      if (!arst_i) begin
         apb_win   = (state == ST_IDLE) && apb_req_i && (!vga_req_i || starved);
         vga_issue = vga_req_i && !apb_win;
      end
   end

   assign rd_issue  = vga_issue | (apb_win & ~apb_we_i);
   assign apb_gnt_o = apb_win;

   // Memory port is driven straight from the winner.
   always_comb begin
      mem_en_o    = apb_win | vga_issue;
      mem_we_o    = apb_win & apb_we_i;
      mem_addr_o  = apb_win ? apb_addr_i : vga_addr_i;
      mem_wdata_o = apb_wdata_i;
   end

   // Read tags ride alongside the memory latency; the exiting tag steers the data.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         tag_v   <= '0;
         tag_apb <= '0;
      end else begin
         tag_v[0]   <= rd_issue;
         tag_apb[0] <= apb_win;
         for (int unsigned i = 1; i < LATENCY; i++) begin
            tag_v[i]   <= tag_v[i-1];
            tag_apb[i] <= tag_apb[i-1];
         end
      end
   end

   assign vga_rvalid_o = tag_v[LATENCY-1] & ~tag_apb[LATENCY-1];
   assign apb_rvalid_o = tag_v[LATENCY-1] &  tag_apb[LATENCY-1];
   assign vga_rdata_o  = mem_rdata_i;
   assign apb_rdata_o  = mem_rdata_i;

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:    if (apb_win && !apb_we_i) state <= ST_RD_WAIT;
            ST_RD_WAIT: if (apb_rvalid_o)         state <= ST_IDLE;
            default:                              state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vgachargen_mem_arb.sv
// Directed bench for vgachargen_mem_arb with a LATENCY=2 behavioural memory stub.
module tb_vgachargen_mem_arb;

   localparam int unsigned AW = 12;
   localparam int unsigned DW = 8;

   logic          clk_i = 1'b0;
   logic          arst_i;
   logic          vga_req_i, apb_req_i, apb_we_i;
   logic [AW-1:0] vga_addr_i, apb_addr_i;
   logic [DW-1:0] apb_wdata_i;
   logic          vga_rvalid_o, vga_miss_o, apb_gnt_o, apb_rvalid_o;
   logic [DW-1:0] vga_rdata_o, apb_rdata_o;
   logic          mem_en_o, mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o, mem_rdata_i;

   int errors = 0;
   int checks = 0;

   vgachargen_mem_arb #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(2), .STARVE_LIMIT(8)
   ) dut (
      .clk_i(clk_i), .arst_i(arst_i),
      .vga_req_i(vga_req_i), .vga_addr_i(vga_addr_i),
      .vga_rvalid_o(vga_rvalid_o), .vga_rdata_o(vga_rdata_o), .vga_miss_o(vga_miss_o),
      .apb_req_i(apb_req_i), .apb_we_i(apb_we_i), .apb_addr_i(apb_addr_i),
      .apb_wdata_i(apb_wdata_i), .apb_gnt_o(apb_gnt_o),
      .apb_rvalid_o(apb_rvalid_o), .apb_rdata_o(apb_rdata_o),
      .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   // Memory stub: unwritten words read as addr[7:0]^0x5A, two-cycle read latency.
   logic          wr_v [0:(1<<AW)-1];
   logic [DW-1:0] wr_d [0:(1<<AW)-1];
   logic [DW-1:0] rdq0, rdq1;
   logic [7:0]    addr_lo;

   assign addr_lo     = mem_addr_o[7:0];
   assign mem_rdata_i = rdq1;

   always @(posedge clk_i) begin
      if (mem_en_o && mem_we_o) begin
         wr_v[mem_addr_o] <= 1'b1;
         wr_d[mem_addr_o] <= mem_wdata_o;
      end
      rdq0 <= (mem_en_o && !mem_we_o) ?
              (wr_v[mem_addr_o] ? wr_d[mem_addr_o] : (addr_lo ^ 8'h5A)) : 8'h00;
      rdq1 <= rdq0;
   end

   typedef struct {
      logic          vr;
      logic [AW-1:0] va;
      logic          ar;
      logic          aw;
      logic [AW-1:0] aa;
      logic [DW-1:0] ad;
      logic          e_en;
      logic          e_we;
      logic [AW-1:0] e_addr;
      logic          e_gnt;
      logic          e_vv;
      logic [DW-1:0] e_vd;
      logic          e_av;
      logic [DW-1:0] e_ad;
   } vec_t;

   vec_t tv[$];

   task automatic row(input logic vr, input logic [AW-1:0] va,
                      input logic ar, input logic aw, input logic [AW-1:0] aa,
                      input logic [DW-1:0] ad, input logic en, input logic we,
                      input logic [AW-1:0] ea, input logic gnt, input logic vv,
                      input logic [DW-1:0] vd, input logic av, input logic [DW-1:0] adt);
      tv.push_back('{vr, va, ar, aw, aa, ad, en, we, ea, gnt, vv, vd, av, adt});
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      vga_req_i   = 1'b0;
      vga_addr_i  = '0;
      apb_req_i   = 1'b0;
      apb_we_i    = 1'b0;
      apb_addr_i  = '0;
      apb_wdata_i = '0;
   endtask

   int gnt_at, miss_n, miss_at, vv_n, av_n, bad_rv;
   logic [DW-1:0] av_last;

   initial begin
      arst_i = 1'b1;
      idle();
      vga_req_i = 1'b1;
      apb_req_i = 1'b1;
      apb_we_i  = 1'b1;

      // Reset: nothing granted, no strobe, no responses, even with both requesters active.
      @(negedge clk_i);
      chk("rst_mem_en", 32'(mem_en_o), 32'd0);
      chk("rst_gnt", 32'(apb_gnt_o), 32'd0);
      chk("rst_vga_rvalid", 32'(vga_rvalid_o), 32'd0);
      chk("rst_apb_rvalid", 32'(apb_rvalid_o), 32'd0);
      chk("rst_miss", 32'(vga_miss_o), 32'd0);
      @(posedge clk_i);
      #1;
      idle();
      arst_i = 1'b0;
      cyc();

      //  vr  va       ar aw aa       ad      en we ea       gnt vv vd     av ad
      row(0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 0, 0, 8'h00, 0, 8'h00);
      row(1, 12'h010, 0, 0, 12'h000, 8'h00, 1, 0, 12'h010, 0, 0, 8'h00, 0, 8'h00);
      row(1, 12'h011, 0, 0, 12'h000, 8'h00, 1, 0, 12'h011, 0, 0, 8'h00, 0, 8'h00);
      row(1, 12'h012, 0, 0, 12'h000, 8'h00, 1, 0, 12'h012, 0, 1, 8'h4A, 0, 8'h00);
      row(0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 0, 1, 8'h4B, 0, 8'h00);
      row(0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 0, 1, 8'h48, 0, 8'h00);
      row(0, 12'h000, 1, 1, 12'h100, 8'hA5, 1, 1, 12'h100, 1, 0, 8'h00, 0, 8'h00);
      row(0, 12'h000, 1, 0, 12'h100, 8'h00, 1, 0, 12'h100, 1, 0, 8'h00, 0, 8'h00);
      row(0, 12'h000, 1, 0, 12'h101, 8'h00, 0, 0, 12'h000, 0, 0, 8'h00, 0, 8'h00);
      row(0, 12'h000, 1, 0, 12'h101, 8'h00, 0, 0, 12'h000, 0, 0, 8'h00, 1, 8'hA5);
      row(0, 12'h000, 1, 0, 12'h101, 8'h00, 1, 0, 12'h101, 1, 0, 8'h00, 0, 8'h00);
      row(1, 12'h020, 0, 0, 12'h000, 8'h00, 1, 0, 12'h020, 0, 0, 8'h00, 0, 8'h00);
      row(0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 0, 0, 8'h00, 1, 8'h5B);
      row(0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 0, 1, 8'h7A, 0, 8'h00);
      row(1, 12'h030, 0, 0, 12'h000, 8'h00, 1, 0, 12'h030, 0, 0, 8'h00, 0, 8'h00);
      row(0, 12'h000, 1, 0, 12'h040, 8'h00, 1, 0, 12'h040, 1, 0, 8'h00, 0, 8'h00);
      row(1, 12'h050, 0, 0, 12'h000, 8'h00, 1, 0, 12'h050, 0, 1, 8'h6A, 0, 8'h00);
      row(0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 0, 0, 8'h00, 1, 8'h1A);
      row(0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 0, 1, 8'h0A, 0, 8'h00);
      row(1, 12'h060, 1, 0, 12'h070, 8'h00, 1, 0, 12'h060, 0, 0, 8'h00, 0, 8'h00);
      row(0, 12'h000, 1, 0, 12'h070, 8'h00, 1, 0, 12'h070, 1, 0, 8'h00, 0, 8'h00);
      row(0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 0, 1, 8'h3A, 0, 8'h00);
      row(0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 0, 0, 8'h00, 1, 8'h2A);
      row(0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 0, 0, 8'h00, 0, 8'h00);

      foreach (tv[r]) begin
         vga_req_i   = tv[r].vr;
         vga_addr_i  = tv[r].va;
         apb_req_i   = tv[r].ar;
         apb_we_i    = tv[r].aw;
         apb_addr_i  = tv[r].aa;
         apb_wdata_i = tv[r].ad;
         @(negedge clk_i);
         chk($sformatf("r%0d_mem_en", r), 32'(mem_en_o), 32'(tv[r].e_en));
         chk($sformatf("r%0d_mem_we", r), 32'(mem_we_o), 32'(tv[r].e_we));
         chk($sformatf("r%0d_gnt", r), 32'(apb_gnt_o), 32'(tv[r].e_gnt));
         chk($sformatf("r%0d_vga_rvalid", r), 32'(vga_rvalid_o), 32'(tv[r].e_vv));
         chk($sformatf("r%0d_apb_rvalid", r), 32'(apb_rvalid_o), 32'(tv[r].e_av));
         chk($sformatf("r%0d_miss", r), 32'(vga_miss_o), 32'd0);
         if (tv[r].e_en) chk($sformatf("r%0d_mem_addr", r), 32'(mem_addr_o), 32'(tv[r].e_addr));
         if (tv[r].e_vv) chk($sformatf("r%0d_vga_rdata", r), 32'(vga_rdata_o), 32'(tv[r].e_vd));
         if (tv[r].e_av) chk($sformatf("r%0d_apb_rdata", r), 32'(apb_rdata_o), 32'(tv[r].e_ad));
         cyc();
      end

      // Starvation: VGA streams every cycle while an APB read of 0x100 waits.
      idle();
      vga_req_i  = 1'b1;
      apb_req_i  = 1'b1;
      apb_addr_i = 12'h100;
      gnt_at = -1; miss_n = 0; miss_at = -1; vv_n = 0; av_n = 0; av_last = '0;
      for (int i = 0; i < 40; i++) begin
         vga_addr_i = AW'(i);
         @(negedge clk_i);
         if (apb_gnt_o && gnt_at < 0) gnt_at = i;
         if (vga_miss_o) begin miss_n++; miss_at = i; end
         if (vga_rvalid_o) vv_n++;
         if (apb_rvalid_o) begin av_n++; av_last = apb_rdata_o; end
         @(posedge clk_i);
         #1;
         if (gnt_at >= 0) apb_req_i = 1'b0;
      end
`ifdef VGACHARGEN_MEM_ARB_STARVE_GUARD_EN
      chk("starve_gnt_cycle", 32'(gnt_at), 32'd8);
      chk("starve_miss_count", 32'(miss_n), 32'd1);
      chk("starve_miss_cycle", 32'(miss_at), 32'd8);
      chk("starve_vga_rvalid_count", 32'(vv_n), 32'd37);
      chk("starve_apb_rvalid_count", 32'(av_n), 32'd1);
      chk("starve_apb_rdata", 32'(av_last), 32'hA5);
`else
      chk("starve_gnt_cycle", 32'(gnt_at), 32'hFFFF_FFFF);
      chk("starve_miss_count", 32'(miss_n), 32'd0);
      chk("starve_vga_rvalid_count", 32'(vv_n), 32'd38);
      chk("starve_apb_rvalid_count", 32'(av_n), 32'd0);
`endif
      idle();
      repeat (4) cyc();

      // Reset with a VGA read and an APB read in flight.
      vga_req_i  = 1'b1;
      vga_addr_i = 12'h010;
      cyc();
      idle();
      apb_req_i  = 1'b1;
      apb_addr_i = 12'h011;
      @(negedge clk_i);
      chk("inflight_apb_gnt", 32'(apb_gnt_o), 32'd1);
      @(posedge clk_i);
      #1;
      arst_i    = 1'b1;
      apb_req_i = 1'b0;
      #1;
      chk("inrst_vga_rvalid", 32'(vga_rvalid_o), 32'd0);
      chk("inrst_apb_rvalid", 32'(apb_rvalid_o), 32'd0);
      chk("inrst_mem_en", 32'(mem_en_o), 32'd0);
      @(posedge clk_i);
      #1;
      arst_i = 1'b0;
      bad_rv = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         if (vga_rvalid_o || apb_rvalid_o) bad_rv++;
         cyc();
      end
      chk("postrst_stray_rvalid", 32'(bad_rv), 32'd0);

      // FSM back in IDLE: a fresh APB read is taken at once.
      apb_req_i  = 1'b1;
      apb_addr_i = 12'h100;
      @(negedge clk_i);
      chk("postrst_gnt", 32'(apb_gnt_o), 32'd1);
      cyc();
      apb_req_i = 1'b0;
      @(negedge clk_i);
      chk("postrst_rvalid_early", 32'(apb_rvalid_o), 32'd0);
      cyc();
      @(negedge clk_i);
      chk("postrst_rvalid", 32'(apb_rvalid_o), 32'd1);
      chk("postrst_rdata", 32'(apb_rdata_o), 32'hA5);
      chk("postrst_vga_rvalid", 32'(vga_rvalid_o), 32'd0);
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
